l2ahb_out_arb: RTL
==================

// Module: l2ahb_out_arb
// PURPOSE
//  Output-stage arbiter for one slave port of the L2 AHB matrix. Collects sel/trans from
//  every input-port decoder targeting this slave, picks one owner per address phase with
//  round-robin fairness, holds ownership through bursts and locked sequences, and tracks
//  the data-phase owner. Drives the per-input active_dec and the output-stage mux selects.
// PARAMETERS
//  NUM_PORTS  3  number of input ports competing for this slave (2..8)
//  PORT_W     2  width of port index, >= clog2(NUM_PORTS)
// PORTS
//  HCLK           in   1            AHB system clock
//  HRESET         in   1            async reset, active-high
//  HREADYM        in   1            HREADY seen by the slave (transfer-boundary strobe)
//  sel_op         in   NUM_PORTS    per-input HSEL from each input decoder
//  trans_op       in   2*NUM_PORTS  per-input HTRANS, port i at [2i+1:2i]
//  lock_op        in   NUM_PORTS    per-input HMASTLOCK
//  active_op      out  NUM_PORTS    per-input active_dec; one-hot or zero
//  addr_in_port   out  PORT_W       input port owning current address phase
//  data_in_port   out  PORT_W       input port owning current data phase
//  no_port        out  1            no owner; output stage drives HTRANS=IDLE
//  slave_sel      out  1            HSEL to slave = ~no_port & sel_op[addr_in_port]
// BEHAVIOUR
//  Reset (HRESET=1, any time): addr_in_port=0, data_in_port=0, no_port=1,
//   active_op=0, slave_sel=0, last_grant=NUM_PORTS-1 so port 0 wins first. No x on outputs.
//  req[i] = sel_op[i] & (trans_op[i]==NONSEQ). SEQ/BUSY never start ownership.
//  hold = ~no_port & sel_op[own] & (lock_op[own] | trans_op[own]==SEQ | trans_op[own]==BUSY)
//   where own = addr_in_port. Lock holds through IDLE while lock_op[own]=1.
//  Update only on HCLK edge with HREADYM=1; HREADYM=0 freezes all state/outputs.
//  On update: if hold -> keep owner. Else if any req -> owner = first req searching
//   last_grant+1 .. wrapping modulo NUM_PORTS; last_grant<=owner; no_port<=0.
//   Else -> no_port<=1, addr_in_port keeps last value (parked).
//  Grant latency: req sampled at HREADYM=1 edge N -> active_op visible in cycle N+1.
//  data_in_port <= addr_in_port on same HREADYM=1 edge (pipelined one phase behind).
//  active_op[i] = ~no_port & (addr_in_port==i), combinational from registered state.
//  Simultaneous reqs: round-robin only; owner re-requesting NONSEQ after burst end
//   loses to any other requester (last_grant already points at it).
//  Owner drops sel_op mid-burst: hold clears, re-arbitrate at next HREADYM=1.
//  Port indices >= NUM_PORTS never produced; unused req bits tied 0.
//  Reset mid-burst: all state to reset values immediately (async), no completion.
// STRUCTURE
//  l2ahb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ localparams, shared with decoders and
//   output stages.
//  Sub-module l2ahb_rr_pick: combinational round-robin picker
//   (req vector, last_grant) -> (grant index, any); reused by other output stages.
//  Top holds owner/last_grant/data_in_port/no_port registers and hold logic.
// TESTING
//  1 Reset release, port1 NONSEQ, HREADYM=1 -> next cycle addr_in_port=1, active_op=3'b010,
//    no_port=0; following edge data_in_port=1.
//  2 Ports 0,1,2 NONSEQ every cycle, single transfers -> grants 0,1,2,0,1,2 in order.
//  3 Port2 INCR4 (NONSEQ,SEQ,SEQ,SEQ) while port0 requests -> port2 holds all 4 beats,
//    port0 granted on edge after last SEQ.
//  4 Port0 lock_op=1 with IDLE gap between transfers, port1 requesting -> port0 keeps
//    ownership until lock_op=0, then port1.
//  5 HREADYM=0 for 3 cycles mid-burst with new requests -> outputs unchanged, arbitration
//    resumes on first HREADYM=1 edge.
//  6 HRESET pulsed mid-burst of port1 -> outputs to reset values same cycle; after release
//    first requester granted, port0 wins a tie.

Source files
------------

// File: rtl/l2ahb_pkg.sv
// ---------------------------------------------------------------------------
// l2ahb_pkg
//   Shared definitions for the L2 AHB matrix: HTRANS encodings used by the
//   input decoders, the output-stage arbiters and the output-stage muxes.
// ---------------------------------------------------------------------------
package l2ahb_pkg;

    // AHB HTRANS transfer-type encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/l2ahb_rr_pick.sv
// ---------------------------------------------------------------------------
// l2ahb_rr_pick
//   Combinational round-robin picker. Searches the request vector starting
//   one position after last_grant and wrapping modulo NUM_PORTS; the first
//   requester found is returned as grant.
// Ports:
//   req        in   NUM_PORTS  request vector, one bit per input port
//   last_grant in   PORT_W     index of the most recently granted port
//   grant      out  PORT_W     chosen port (meaningful only when any=1)
//   any        out  1          at least one request is present
// ---------------------------------------------------------------------------
module l2ahb_rr_pick #(
    parameter int NUM_PORTS = 3,
    parameter int PORT_W    = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    last_grant,
    output logic [PORT_W-1:0]    grant,
    output logic                 any
);

    // The search distance k runs from farthest to nearest, so the requester
    // closest after last_grant overwrites every farther one and wins.
    always_comb begin
        grant = last_grant;
        any   = |req;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (req[j] && (((int'(last_grant) + k) % NUM_PORTS) == j)) begin
                    grant = PORT_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/l2ahb_out_arb.sv
// ---------------------------------------------------------------------------
// l2ahb_out_arb
//   Output-stage arbiter for one slave port of the L2 AHB matrix. Picks one
//   address-phase owner among the input ports with round-robin fairness,
//   keeps it through bursts (SEQ/BUSY) and locked sequences, and tracks the
//   data-phase owner one transfer behind.
// Ports:
//   HCLK          in   1            AHB system clock
//   HRESET        in   1            asynchronous reset, active-high
//   HREADYM       in   1            transfer-boundary strobe from the slave
//   sel_op        in   NUM_PORTS    per-input HSEL from each input decoder
//   trans_op      in   2*NUM_PORTS  per-input HTRANS, port i at [2i+1:2i]
//   lock_op       in   NUM_PORTS    per-input HMASTLOCK
//   active_op     out  NUM_PORTS    per-input active_dec, one-hot or zero
//   addr_in_port  out  PORT_W       owner of the current address phase
//   data_in_port  out  PORT_W       owner of the current data phase
//   no_port       out  1            no owner, output stage drives IDLE
//   slave_sel     out  1            HSEL presented to the slave
// ---------------------------------------------------------------------------
module l2ahb_out_arb
    import l2ahb_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int PORT_W    = 2
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HREADYM,
    input  logic [NUM_PORTS-1:0]   sel_op,
    input  logic [2*NUM_PORTS-1:0] trans_op,
    input  logic [NUM_PORTS-1:0]   lock_op,
    output logic [NUM_PORTS-1:0]   active_op,
    output logic [PORT_W-1:0]      addr_in_port,
    output logic [PORT_W-1:0]      data_in_port,
    output logic                   no_port,
    output logic                   slave_sel
);

    logic [NUM_PORTS-1:0] req;
    logic [PORT_W-1:0]    last_grant;
    logic [PORT_W-1:0]    pick_grant;
    logic                 pick_any;
    logic                 own_sel;
    logic                 own_lock;
    logic [1:0]           own_trans;
    logic                 hold;

    // Only a NONSEQ to this slave can start a new ownership; SEQ/BUSY are
    // continuations and must never steal the slave from its owner.
    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            req[j] = sel_op[j] && (trans_op[2*j +: 2] == HTRANS_NONSEQ);
        end
    end

    // Select the current owner's sel/lock/trans with a compare loop rather
    // than a variable index, so an out-of-range index can never be read.
    always_comb begin
        own_sel   = 1'b0;
        own_lock  = 1'b0;
        own_trans = HTRANS_IDLE;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (addr_in_port == PORT_W'(j)) begin
                own_sel   = sel_op[j];
                own_lock  = lock_op[j];
                own_trans = trans_op[2*j +: 2];
            end
        end
    end

    // The owner keeps the slave while it is still selecting it and is either
    // inside a burst or locked; a lock holds even across IDLE transfers.
    always_comb begin
        hold = !no_port && own_sel &&
               (own_lock || (own_trans == HTRANS_SEQ) || (own_trans == HTRANS_BUSY));
    end

    l2ahb_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .any        (pick_any)
    );

    // Ownership only changes on a transfer boundary. last_grant resets to the
    // highest port so the first search starts at port 0. When nobody asks,
    // addr_in_port stays parked on the previous owner with no_port raised.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_in_port <= '0;
            data_in_port <= '0;
            no_port      <= 1'b1;
            last_grant   <= PORT_W'(NUM_PORTS - 1);
        end else if (HREADYM) begin
            data_in_port <= addr_in_port;
            if (!hold) begin
                if (pick_any) begin
                    addr_in_port <= pick_grant;
                    last_grant   <= pick_grant;
                    no_port      <= 1'b0;
                end else begin
                    no_port      <= 1'b1;
                end
            end
        end
    end

    // Decoder handshakes and slave select, derived only from registered
    // ownership plus the owner's live HSEL.
    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            active_op[j] = !no_port && (addr_in_port == PORT_W'(j));
        end
        slave_sel = !no_port && own_sel;
    end

endmodule
